// File: rtl/pattern_match_unit.sv
// rtl/pattern_match_unit.sv - byte-serial pattern matcher with sticky match flag and 4-phase handshake
module pattern_match_unit #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [15:0]       control,
    input  logic              data_ready,
    output logic              data_accepted,
    output logic              pattern_accepted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_MATCH = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_cmd_data;
    logic [2:0]        r_byte_idx;
    logic [63:0]       r_pattern;
    logic [3:0]        r_len;
    logic [63:0]       r_hist;
    logic [3:0]        r_valid;
    logic              r_data_accepted;
    logic              r_pattern_accepted;

    logic [7:0]        w_shift_byte;
    logic [63:0]       w_hist_next;
    logic [3:0]        w_valid_next;
    logic [63:0]       w_bad;
    logic              w_match;
    logic              w_unused;

    assign w_unused = ^control[10:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (data_ready) begin
                    w_next_state = (control[15:14] == OP_MATCH) ? SCAN : ACK;
                end
            end
            SCAN: begin
                if (r_byte_idx == 3'd7) begin
                    w_next_state = ACK;
                end
            end
            ACK: begin
                if (!data_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // History byte k is the byte shifted in k shifts ago (byte 0 = newest).
    assign w_shift_byte = r_cmd_data[{r_byte_idx, 3'b000} +: 8];
    assign w_hist_next  = {r_hist[55:0], w_shift_byte};
    assign w_valid_next = (r_valid == 4'd8) ? 4'd8 : r_valid + 4'd1;

    // Pattern byte j must sit at history position L-1-j, i.e. k + j + 1 == L.
    for (genvar k = 0; k < 8; k++) begin : g_pos
        for (genvar j = 0; j < 8; j++) begin : g_pat
            assign w_bad[k*8+j] = (r_len == 4'(k + j + 1)) &&
                                  (w_hist_next[k*8 +: 8] != r_pattern[j*8 +: 8]);
        end
    end

    assign w_match = (w_valid_next >= r_len) && !(|w_bad);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_data         <= '0;
            r_byte_idx         <= 3'd0;
            r_pattern          <= '0;
            r_len              <= 4'd1;
            r_hist             <= '0;
            r_valid            <= 4'd0;
            r_data_accepted    <= 1'b0;
            r_pattern_accepted <= 1'b0;
        end else begin
            r_data_accepted <= (w_next_state == ACK);
            case (r_state)
                IDLE: begin
                    if (data_ready) begin
                        r_cmd_data <= data;
                        r_byte_idx <= 3'd0;
                        case (control[15:14])
                            OP_LOAD: begin
                                r_pattern          <= data[63:0];
                                r_len              <= {1'b0, control[13:11]} + 4'd1;
                                r_hist             <= '0;
                                r_valid            <= 4'd0;
                                r_pattern_accepted <= 1'b0;
                            end
                            OP_CLEAR: begin
                                r_hist             <= '0;
                                r_valid            <= 4'd0;
                                r_pattern_accepted <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                SCAN: begin
                    r_hist     <= w_hist_next;
                    r_valid    <= w_valid_next;
                    r_byte_idx <= r_byte_idx + 3'd1;
                    if (w_match) begin
                        r_pattern_accepted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_accepted    = r_data_accepted;
    assign pattern_accepted = r_pattern_accepted;

endmodule

// File: doc/pattern_match_unit.md
PATTERN_MATCH_UNIT -- requirements
Module: pattern_match_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning command data width in bits (8 bytes per command; other values unsupported).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: data  input  64  command payload; byte i = data[8i+7:8i], byte 0 first.
REQ-005 SHALL have port: control  input  16  command word; [15:14] opcode, [13:11] pattern length minus 1, [10:0] ignored.
REQ-006 SHALL have port: data_ready  input  1  level request from the register interface; data and control are stable while high.
REQ-007 SHALL have port: data_accepted  output  1  registered handshake acknowledge.
REQ-008 SHALL have port: pattern_accepted  output  1  registered sticky match flag.

Function
REQ-009 SHALL decode opcodes as: 00 NOP, 01 LOAD_PAT, 10 MATCH, 11 CLEAR.
REQ-010 SHALL implement states IDLE, SCAN, ACK.
REQ-011 SHALL, in IDLE with data_ready=1, latch data and control on edge T.
REQ-012 SHALL, for NOP/LOAD_PAT/CLEAR, go to ACK on edge T, with data_accepted=1 visible after edge T.
REQ-013 SHALL, on LOAD_PAT, store pattern=data and L=control[13:11]+1 (range 1..8).
REQ-014 SHALL, on LOAD_PAT, clear history valid count and pattern_accepted on the same edge.
REQ-015 SHALL, on CLEAR, zero history, valid count and pattern_accepted, and keep pattern and L.
REQ-016 SHALL, on MATCH, enter SCAN on edge T.
REQ-017 SHALL, in SCAN, shift in one byte per edge, bytes 0..7 on edges T+1..T+8.
REQ-018 SHALL go to ACK on edge T+8, with data_accepted=1 visible after edge T+8.
REQ-019 SHALL hold an 8-byte history shift register and a valid count saturating at 8.
REQ-020 SHALL keep history and valid count across MATCH commands, so matches can span command boundaries.
REQ-021 SHALL define a match after a shift as: valid count (post-shift) >= L and, for j=0..L-1, the byte shifted in L-1-j shifts ago equals pattern byte j.
REQ-022 SHALL set pattern_accepted on the same edge that shifts in the completing byte.
REQ-023 SHALL keep pattern_accepted at 1 until LOAD_PAT, CLEAR or reset.
REQ-024 SHALL, in ACK, hold data_accepted=1 while data_ready=1.
REQ-025 SHALL, in ACK with data_ready=0, return to IDLE and drive data_accepted=0 on the next edge (4-phase handshake).
REQ-026 SHALL execute exactly one command per data_ready assertion; a held-high data_ready after ACK never re-triggers.
REQ-027 SHALL ignore data and control changes during SCAN and ACK; the latched copy is used.
REQ-028 SHALL ignore data_ready=0 in IDLE, holding all state.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state=IDLE and data_accepted=0.
REQ-030 SHALL, while reset=0, asynchronously force pattern_accepted=0, pattern=0, L=1, history=0 and valid count=0.
REQ-031 SHALL, on reset during SCAN, abort the scan with no acknowledge; after release the block waits in IDLE.
REQ-032 SHALL, on reset during SCAN with data_ready still high, start that command afresh after release.

Verification
REQ-033 SHALL cover reset: assert reset=0 mid-SCAN -> data_accepted=0 and pattern_accepted=0 immediately, without waiting for a clock edge.
REQ-034 SHALL cover an in-block match: LOAD_PAT control=0x4800, data=0x000000000000BBAA (L=2, pattern AA,BB), then MATCH control=0x8000, data=0x0000000000BBAA00 -> pattern_accepted rises on edge T+3 and data_accepted rises on edge T+8.
REQ-035 SHALL cover a cross-block match: with the same pattern, MATCH data=0xAA00000000000000 then MATCH data=0x00000000000000BB -> pattern_accepted=0 after the first command and rises on edge T+1 of the second.
REQ-036 SHALL cover CLEAR: after a match, command control=0xC000 -> pattern_accepted=0 after edge T; then MATCH with data=0x00000000000000BB -> no match, since history was cleared.
REQ-037 SHALL cover the handshake: hold data_ready=1 for 30 cycles after one MATCH -> exactly one scan and data_accepted stays 1; drop data_ready -> data_accepted=0 one edge later; re-raise -> a new command executes.
REQ-038 SHALL cover L=8 with a self-overlapping pattern: LOAD_PAT control=0x7800, data=0x0101010101010101, then MATCH data=0x0101010101010101 -> pattern_accepted rises on edge T+8, not earlier.
